// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU:
// opcodes, FSM states and the default datapath width.
package alu_seq_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic is_shift(
    input logic [2:0] op
  );
    return (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle arithmetic/logic unit for add, sub, and, or.
// Shift and reserved opcodes produce zero here.
module alu_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] c
);

  always_comb begin
    c = '0;
    unique case (1'b1)
      (op == OP_ADD): c = a + b;
      (op == OP_SUB): c = a - b;
      (op == OP_AND): c = a & b;
      (op == OP_OR):  c = a | b;
      default:        c = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with a bit-serial right shifter
// and a wrapping count of delivered results.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             busy,
  output logic [15:0]      op_count
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] work_q;
  logic [5:0]       cnt_q;
  logic             sra_q;
  logic [15:0]      op_count_q;
  logic [WIDTH-1:0] alu_c;
  logic [5:0]       n_sat;
  logic             in_fire;
  logic             out_fire;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a  (in_a),
    .b  (in_b),
    .op (in_op),
    .c  (alu_c)
  );

  // Any amount of 32 or more behaves like 32.
  assign n_sat = (|in_b[WIDTH-1:5])
               ? 6'd32
               : {1'b0, in_b[4:0]};

  assign in_ready  = !reset && (state_q == IDLE);
  assign out_valid = !reset && (state_q == DONE);
  assign busy      = !reset && (state_q != IDLE);
  assign out_c     = out_valid ? work_q : '0;
  assign op_count  = op_count_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          if (is_shift(in_op) && (n_sat != 6'd0))
            state_d = SHIFT;
          else
            state_d = DONE;
        end
      end
      SHIFT: begin
        if (cnt_q == 6'd1)
          state_d = DONE;
      end
      DONE: begin
        if (out_fire)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      sra_q      <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (in_fire) begin
            if (is_shift(in_op)) begin
              work_q <= in_a;
              cnt_q  <= n_sat;
              sra_q  <= (in_op == OP_SRA);
            end else begin
              work_q <= alu_c;
            end
          end
        end
        SHIFT: begin
          work_q <= {sra_q & work_q[WIDTH-1],
                     work_q[WIDTH-1:1]};
          cnt_q  <= cnt_q - 6'd1;
        end
        DONE: begin
          if (out_fire)
            op_count_q <= op_count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  command present.
REQ-005 in_ready  output  1  block accepts a command this cycle.
REQ-006 in_op  input  3  operation code.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B; shift amount for shift ops.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out_c  output  WIDTH  result.
REQ-012 busy  output  1  command accepted and not yet delivered.
REQ-013 op_count  output  16  count of results delivered.

Function
REQ-014 Opcodes SHALL be: 000 add, 001 sub, 010 and, 011 or, 100 logical right shift, 101 arithmetic right shift, 110/111 result 0.
REQ-015 Add/sub SHALL be modulo 2^WIDTH; carry and overflow discarded.
REQ-016 Command transfer SHALL occur in a cycle with in_valid=1 and in_ready=1; result transfer in a cycle with out_valid=1 and out_ready=1.
REQ-017 FSM states SHALL be IDLE, SHIFT, DONE; in_ready=1 only in IDLE with reset low; busy=1 in SHIFT and DONE; out_valid=1 only in DONE.
REQ-018 IDLE with no transfer SHALL remain in IDLE; in_op/in_a/in_b are ignored unless a transfer occurs.
REQ-019 IDLE with transfer of a non-shift op SHALL register the result and enter DONE; out_valid rises in the cycle after transfer.
REQ-020 IDLE with transfer of a shift op SHALL load A and shift count n = in_b if in_b<32, else 32 (saturated).
REQ-021 n=0 SHALL enter DONE with result = A.
REQ-022 n>=1 SHALL enter SHIFT; each SHIFT cycle shifts the working register right by one bit (zero fill for 100, sign fill for 101) and decrements n; DONE is entered when n reaches 0.
REQ-023 Shift latency SHALL be exactly n+1 cycles from transfer to first out_valid; saturated srl yields 0, saturated sra yields all bits equal to A[WIDTH-1].
REQ-024 In DONE, out_c and out_valid SHALL hold stable until result transfer; on transfer the FSM returns to IDLE and op_count increments by 1.
REQ-025 op_count SHALL wrap 0xFFFF -> 0x0000.
REQ-026 No command SHALL be accepted in the cycle a result transfers; the earliest next acceptance is the following cycle.
REQ-027 out_c SHALL be 0 whenever out_valid=0.

Reset
REQ-028 Reset high at a rising edge SHALL force IDLE, working register 0, shift count 0, op_count 0, from any state including mid-shift.
REQ-029 While reset is high: in_ready=0, out_valid=0, busy=0, out_c=0; an in-flight command is discarded and not counted.
REQ-030 The first command is accepted no earlier than the first cycle with reset low.

Structure
REQ-031 A shared package SHALL hold the opcode constants, the FSM state enumeration and the WIDTH default.
REQ-032 Add/sub/and/or SHALL be a combinational sub-module alu_comb (A, B, op -> C); shifting stays inside alu_seq.

Verification
REQ-033 add: A=0xFFFFFFFF, B=1, op 000 -> out_c=0x00000000, out_valid exactly 1 cycle after transfer.
REQ-034 sra: A=0x80000000, B=4, op 101 -> out_c=0xF8000000 after exactly 5 cycles; op 100 with same operands -> 0x08000000.
REQ-035 Saturation: A=0x80000001, B=0x00000100, op 101 -> 0xFFFFFFFF after 33 cycles; op 100 -> 0x00000000; B=0 -> out_c=A after 1 cycle.
REQ-036 Backpressure: out_ready=0 for 10 cycles -> out_c/out_valid stable, in_ready=0, in_valid pulses ignored, op_count unchanged until release.
REQ-037 Reset at cycle 3 of a B=20 shift -> next cycle all outputs 0, op_count 0; a new sub 5-7 then yields 0xFFFFFFFE.
REQ-038 Preload 0xFFFF deliveries (or 65536 back-to-back ops) -> op_count wraps to 0x0000.
